// File: rtl/alu_top_if.sv
// alu_top_if: operand/decode bus of the execute-stage ALU.
// master drives instruction fields and operands; slave (the ALU) returns
// the decoded operation and the result.
interface alu_top_if;
  logic [6:0]  opcode;
  logic [2:0]  funct;
  logic        add_rshift_type;
  logic [31:0] A;
  logic [31:0] B;
  logic [3:0]  ALUop;
  logic [31:0] Out;

  modport master (
    output opcode, funct, add_rshift_type, A, B,
    input  ALUop, Out
  );

  modport slave (
    input  opcode, funct, add_rshift_type, A, B,
    output ALUop, Out
  );
endinterface

// File: rtl/alu_top.sv
// alu_top: RV32I ALU plus opcode/funct decoder for the execute stage.
// Compile-time option ALU_OUT_REG_EN: when defined, Out is registered on the
// rising edge of Clock (latency 1, synchronous active-high Reset clears it).
// When undefined, Out is purely combinational and Clock/Reset are unused.
// ALUop is combinational in both builds.
module alu_top (
  input  logic       Clock,
  input  logic       Reset,
  alu_top_if.slave   bus
);

  localparam logic [3:0] OP_ADD    = 4'd0;
  localparam logic [3:0] OP_SUB    = 4'd1;
  localparam logic [3:0] OP_AND    = 4'd2;
  localparam logic [3:0] OP_OR     = 4'd3;
  localparam logic [3:0] OP_XOR    = 4'd4;
  localparam logic [3:0] OP_SLT    = 4'd5;
  localparam logic [3:0] OP_SLTU   = 4'd6;
  localparam logic [3:0] OP_SLL    = 4'd7;
  localparam logic [3:0] OP_SRL    = 4'd8;
  localparam logic [3:0] OP_SRA    = 4'd9;
  localparam logic [3:0] OP_COPY_B = 4'd10;
  localparam logic [3:0] OP_XXX    = 4'd15;

  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  logic [3:0]  alu_op;
  logic [31:0] result;
  logic [4:0]  shamt;

  assign shamt = bus.B[4:0];

  // Decode opcode/funct3/bit30 into the ALU operation code.
  always_comb begin
    alu_op = OP_XXX;
    case (bus.opcode)
      OPC_RTYPE, OPC_ITYPE: begin
        case (bus.funct)
          3'b000: begin
            // For I-type, bit 30 is part of the immediate, so ADDI never subtracts.
            if (bus.opcode == OPC_RTYPE && bus.add_rshift_type) alu_op = OP_SUB;
            else                                                alu_op = OP_ADD;
          end
          3'b001: alu_op = OP_SLL;
          3'b010: alu_op = OP_SLT;
          3'b011: alu_op = OP_SLTU;
          3'b100: alu_op = OP_XOR;
          3'b101: alu_op = bus.add_rshift_type ? OP_SRA : OP_SRL;
          3'b110: alu_op = OP_OR;
          3'b111: alu_op = OP_AND;
          default: alu_op = OP_XXX;
        endcase
      end
      OPC_LUI: alu_op = OP_COPY_B;
      OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE: alu_op = OP_ADD;
      default: alu_op = OP_XXX;
    endcase
  end

  // Compute the ALU result for the decoded operation; unused codes give zero.
  always_comb begin
    result = 32'h0;
    case (alu_op)
      OP_ADD:    result = bus.A + bus.B;
      OP_SUB:    result = bus.A - bus.B;
      OP_AND:    result = bus.A & bus.B;
      OP_OR:     result = bus.A | bus.B;
      OP_XOR:    result = bus.A ^ bus.B;
      OP_SLT:    result = {31'b0, ($signed(bus.A) < $signed(bus.B))};
      OP_SLTU:   result = {31'b0, (bus.A < bus.B)};
      OP_SLL:    result = bus.A << shamt;
      OP_SRL:    result = bus.A >> shamt;
      OP_SRA:    result = $unsigned($signed(bus.A) >>> shamt);
      OP_COPY_B: result = bus.B;
      default:   result = 32'h0;
    endcase
  end

  assign bus.ALUop = alu_op;

`ifdef ALU_OUT_REG_EN
  logic [31:0] out_q;

  // Register the result; Reset wins over the computed value.
  always_ff @(posedge Clock) begin
    if (Reset) out_q <= 32'h0;
    else       out_q <= result;
  end

  assign bus.Out = out_q;
`else
  // Clock and Reset have no function in the combinational build.
  logic unused_clk_rst;
  assign unused_clk_rst = Clock | Reset;

  assign bus.Out = result;
`endif

endmodule

// File: tb/tb_alu_top.sv
// tb_alu_top: directed self-checking bench for alu_top.
// Works in both builds; with ALU_OUT_REG_EN defined, Out is checked one
// rising edge after the inputs are applied and reset behaviour is exercised.
module tb_alu_top;

  logic Clock;
  logic Reset;
  int   checks;
  int   errors;

  alu_top_if bus ();

  alu_top u_dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check4(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Apply one vector, check ALUop immediately and Out after the build's latency.
  task automatic vec(input string tag, input logic [6:0] op, input logic [2:0] f,
                     input logic b30, input logic [31:0] a, input logic [31:0] b,
                     input logic [3:0] exp_op, input logic [31:0] exp_out);
    bus.opcode          = op;
    bus.funct           = f;
    bus.add_rshift_type = b30;
    bus.A               = a;
    bus.B               = b;
    #1;
    check4({tag, "_op"}, bus.ALUop, exp_op);
`ifdef ALU_OUT_REG_EN
    @(posedge Clock);
    #1;
`endif
    check32({tag, "_out"}, bus.Out, exp_out);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    Reset  = 1'b1;
    bus.opcode          = 7'b0110011;
    bus.funct           = 3'b000;
    bus.add_rshift_type = 1'b0;
    bus.A               = 32'd0;
    bus.B               = 32'd0;

    repeat (2) @(posedge Clock);
    #1;
`ifdef ALU_OUT_REG_EN
    check32("reset_out", bus.Out, 32'h0);
`endif
    Reset = 1'b0;

    // R-type ADD / SUB
    vec("r_add",  7'b0110011, 3'b000, 1'b0, 32'h00000005, 32'h00000007, 4'd0, 32'h0000000C);
    vec("r_sub",  7'b0110011, 3'b000, 1'b1, 32'h00000005, 32'h00000007, 4'd1, 32'hFFFFFFFE);
    vec("r_sub0", 7'b0110011, 3'b000, 1'b1, 32'h00000000, 32'h00000001, 4'd1, 32'hFFFFFFFF);
    // I-type shifts, B[31:5] ignored
    vec("i_srl",  7'b0010011, 3'b101, 1'b0, 32'h80000010, 32'h00000024, 4'd8, 32'h08000001);
    vec("i_sra",  7'b0010011, 3'b101, 1'b1, 32'h80000010, 32'h00000024, 4'd9, 32'hF8000001);
    vec("r_srl31",7'b0110011, 3'b101, 1'b0, 32'h80000000, 32'h0000001F, 4'd8, 32'h00000001);
    vec("r_sra31",7'b0110011, 3'b101, 1'b1, 32'h80000000, 32'h0000001F, 4'd9, 32'hFFFFFFFF);
    vec("r_sll",  7'b0110011, 3'b001, 1'b0, 32'h00000003, 32'hFFFFFFE4, 4'd7, 32'h00000030);
    vec("i_sll",  7'b0010011, 3'b001, 1'b0, 32'h00000001, 32'h0000001F, 4'd7, 32'h80000000);
    // Set-less-than, signed vs unsigned
    vec("r_slt",  7'b0110011, 3'b010, 1'b0, 32'hFFFFFFFF, 32'h00000001, 4'd5, 32'h00000001);
    vec("r_sltu", 7'b0110011, 3'b011, 1'b0, 32'hFFFFFFFF, 32'h00000001, 4'd6, 32'h00000000);
    vec("r_slt2", 7'b0110011, 3'b010, 1'b0, 32'h00000001, 32'hFFFFFFFF, 4'd5, 32'h00000000);
    vec("i_sltu2",7'b0010011, 3'b011, 1'b0, 32'h00000001, 32'hFFFFFFFF, 4'd6, 32'h00000001);
    // Logic ops
    vec("r_and",  7'b0110011, 3'b111, 1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 4'd2, 32'hF000F000);
    vec("r_or",   7'b0110011, 3'b110, 1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 4'd3, 32'hFFF0FFF0);
    vec("i_xor",  7'b0010011, 3'b100, 1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 4'd4, 32'h0FF00FF0);
    // ADDI ignores bit 30
    vec("i_addi", 7'b0010011, 3'b000, 1'b1, 32'h00000010, 32'h00000020, 4'd0, 32'h00000030);
    // Other opcodes
    vec("lui",    7'b0110111, 3'b000, 1'b0, 32'h12345678, 32'hABCDE000, 4'd10, 32'hABCDE000);
    vec("jalr",   7'b1100111, 3'b000, 1'b0, 32'h00000100, 32'h00000004, 4'd0, 32'h00000104);
    vec("auipc",  7'b0010111, 3'b111, 1'b1, 32'h00001000, 32'h00002000, 4'd0, 32'h00003000);
    vec("jal",    7'b1101111, 3'b101, 1'b1, 32'h00000008, 32'h00000010, 4'd0, 32'h00000018);
    vec("branch", 7'b1100011, 3'b001, 1'b1, 32'h00000004, 32'hFFFFFFFC, 4'd0, 32'h00000000);
    vec("load",   7'b0000011, 3'b010, 1'b0, 32'h00000020, 32'h00000004, 4'd0, 32'h00000024);
    vec("store",  7'b0100011, 3'b010, 1'b1, 32'h00000030, 32'h0000000C, 4'd0, 32'h0000003C);
    vec("invalid",7'b1111111, 3'b000, 1'b0, 32'h00000005, 32'h00000007, 4'd15, 32'h00000000);

`ifdef ALU_OUT_REG_EN
    // Reset asserted mid-stream overrides the computed result.
    Reset = 1'b1;
    repeat (2) @(posedge Clock);
    #1;
    check32("reg_reset2", bus.Out, 32'h0);
    Reset = 1'b0;
    bus.opcode = 7'b0110011; bus.funct = 3'b000; bus.add_rshift_type = 1'b0;
    bus.A = 32'd3; bus.B = 32'd4;
    @(posedge Clock);
    #1;
    check32("reg_add", bus.Out, 32'd7);
    bus.A = 32'd10; bus.B = 32'd20;
    Reset = 1'b1;
    @(posedge Clock);
    #1;
    check32("reg_midreset", bus.Out, 32'h0);
    Reset = 1'b0;
    @(posedge Clock);
    #1;
    check32("reg_after", bus.Out, 32'd30);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_top.md
# alu_top

Combinational RV32I ALU with its opcode/funct decoder, used in the execute stage of the RISC-V processor. The decoder maps instruction fields (opcode, funct3, bit 30) to a 4-bit ALU operation code. The ALU applies that operation to two 32-bit operands. An optional output register, enabled at compile time, turns the result path into a one-cycle pipelined stage.

## Interface
- No parameters.
- Clock  input  1  system clock; used only when the output register is compiled in.
- Reset  input  1  synchronous, active-high reset; clears the output register when it is compiled in.
- opcode  input  7  instruction bits [6:0].
- funct  input  3  instruction funct3, bits [14:12].
- add_rshift_type  input  1  instruction bit 30; selects SUB vs ADD and SRA vs SRL.
- A  input  32  operand A (rs1 or PC, muxed upstream).
- B  input  32  operand B (rs2 or immediate, muxed upstream).
- ALUop  output  4  decoded operation, always combinational.
- Out  output  32  ALU result.

## Operation
ALUop encoding:
- 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR
- 5 SLT, 6 SLTU, 7 SLL, 8 SRL, 9 SRA
- 10 COPY_B
- 15 XXX (invalid)
- Codes 11–14 are unused and behave like XXX.

Decoder, R-type (opcode 0110011), by funct:
- 000: SUB if add_rshift_type, else ADD
- 001: SLL
- 010: SLT
- 011: SLTU
- 100: XOR
- 101: SRA if add_rshift_type, else SRL
- 110: OR
- 111: AND

Decoder, I-type arithmetic (opcode 0010011):
- Same mapping as R-type, except funct 000 is always ADD; add_rshift_type is ignored there because bit 30 belongs to the immediate.
- funct 101 still uses add_rshift_type (SRAI vs SRLI).

Decoder, other opcodes:
- LUI (0110111): COPY_B.
- ADD for AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011. These are address/target computations; branch comparisons are done outside this block.
- Any other opcode: XXX.

ALU:
- ADD/SUB: modulo 2^32, no overflow flag.
- AND/OR/XOR: bitwise.
- SLT: 32'd1 if $signed(A) < $signed(B), else 0.
- SLTU: same as SLT but unsigned.
- SLL/SRL/SRA: shift A by B[4:0]; B[31:5] ignored. SRA replicates A[31].
- COPY_B: Out = B.
- XXX or unused codes: Out = 32'h0.
- The result is a pure function of current inputs, with no internal state except the optional register.

## Timing
- Without ALU_OUT_REG_EN:
  - ALUop and Out are combinational; zero latency.
  - Clock and Reset are unused; no reset value applies.
- With ALU_OUT_REG_EN:
  - ALUop stays combinational. Out is registered on the rising edge of Clock, so it reflects the inputs from the previous cycle (latency 1).
  - Reset high at an edge loads Out = 32'h0. This takes priority over the computed result, including when reset asserts mid-stream.
  - The first valid result appears one cycle after Reset deasserts.

## Configuration
- ALU_OUT_REG_EN defined: Out is registered as described in Timing.
- ALU_OUT_REG_EN undefined: Out is driven directly by the combinational result.
- Decoder and ALU functions are identical in both builds.

## Test plan
- R-type ADD vs SUB: opcode 0110011, funct 000, A=0x00000005, B=0x00000007.
  - add_rshift_type=0 → ALUop=0, Out=0x0000000C.
  - add_rshift_type=1 → ALUop=1, Out=0xFFFFFFFE.
- I-type shifts: opcode 0010011, funct 101, A=0x80000010, B=0x00000024 (shift amount 4).
  - add_rshift_type=0 → Out=0x08000001.
  - add_rshift_type=1 → Out=0xF8000001.
- Set-less-than: R-type, A=0xFFFFFFFF, B=0x00000001.
  - funct 010 → Out=1.
  - funct 011 → Out=0.
- I-type ADDI ignores bit 30: opcode 0010011, funct 000, add_rshift_type=1, A=0x10, B=0x20 → ALUop=0, Out=0x30.
- LUI, JALR and invalid opcode:
  - opcode 0110111, B=0xABCDE000 → ALUop=10, Out=0xABCDE000.
  - opcode 1100111, A=0x100, B=0x4 → Out=0x104.
  - opcode 1111111 → ALUop=15, Out=0x0.
- ALU_OUT_REG_EN build:
  - Reset high for 2 cycles → Out=0.
  - Apply ADD 3+4 → Out=7 one edge later.
  - Assert Reset with new inputs → Out=0 at that edge.
